wt_cache: RTL and testbench
===========================

# wt_cache

Direct-mapped, write-through, write-no-allocate cache between `core_top`'s memory port and `memory_model`. It speaks the same level-request / one-cycle-response handshake on both faces, so it drops in transparently. Read hits finish in one cycle and hide the memory `DELAY`. Misses and all writes are forwarded to memory.

## Interface
- `ADDR_WIDTH`, 32: byte-address width on both faces.
- `DATA_WIDTH`, 32: word width; one word per line.
- `LINES`, 16: line count; power of two, ≥2. `IDX_W = $clog2(LINES)`.
- `clk`  in  1: clock.
- `rst`  in  1: synchronous, active-high reset.
- `cpu_read`, `cpu_write`  in  1: core request, held until `cpu_resp`.
- `cpu_addr`  in  ADDR_WIDTH: byte address, word-aligned; bits [1:0] ignored.
- `cpu_wdata`  in  DATA_WIDTH: store data.
- `cpu_rdata`  out  DATA_WIDTH: load data, valid while `cpu_resp`=1.
- `cpu_resp`  out  1: one-cycle completion pulse.
- `mem_read`, `mem_write`  out  1: memory request, held until `mem_resp`.
- `mem_addr`  out  ADDR_WIDTH; `mem_wdata`  out  DATA_WIDTH.
- `mem_rdata`  in  DATA_WIDTH; `mem_resp`  in  1.
- `hit_count`, `miss_count`  out  32: statistics (see Configuration).

## Operation
- Address split: index = `addr[2 +: IDX_W]`; tag = `addr[ADDR_WIDTH-1 : 2+IDX_W]`.
- Storage per line: valid bit, tag, data word.
- FSM states:
  - IDLE: samples the request, latches addr/wdata. Read hit → RESP. Read miss → FILL. Write → WRITE.
  - FILL: `mem_read`=1 with the latched addr. On `mem_resp`: write the line (valid=1, tag, data), latch `mem_rdata` into `cpu_rdata`, go to RESP.
  - WRITE: `mem_write`=1 with the latched addr/wdata. On `mem_resp`: if the tag hits, update the line data; on a tag miss, do not allocate. Go to RESP.
  - RESP: `cpu_resp`=1 for exactly one cycle, then IDLE.
- Read hit: `cpu_rdata` is taken from the array in the IDLE cycle and registered.
- `cpu_read` and `cpu_write` high together: treated as a write.
- `mem_resp` arriving in IDLE or RESP is ignored.
- `mem_addr`/`mem_wdata` are the latched values and stay stable for the whole memory request.

## Timing
- Reset values:
  - all outputs 0;
  - all valid bits 0;
  - state IDLE;
  - counters 0.
  - Tags and data are not reset.
- Reset mid-FILL/WRITE: `mem_read`/`mem_write` drop the next cycle, the cache is invalidated, and any late `mem_resp` is ignored.
- Request sampled in IDLE at cycle N:
  - read hit: `cpu_resp` at N+1;
  - miss/write: `mem_*` asserted N+1 through `mem_resp` cycle M, `cpu_resp` at M+1.
- One request in flight. No request is accepted in the RESP cycle. The core drops its request after seeing `cpu_resp`, so the next IDLE cycle sees only a new request.

## Configuration
- `WT_CACHE_STATS_EN` defined:
  - `hit_count` increments on each read hit, saturating at 0xFFFF_FFFF.
  - `miss_count` increments on each read miss, same saturation.
  - Writes are not counted.
  - Both counters clear on `rst`.
- Undefined: both ports are tied to 0 and no counter flops exist. The port list is identical either way.

## Structure
- `wt_cache_pkg`:
  - state enum (IDLE, FILL, WRITE, RESP);
  - `STAT_W`=32;
  - helper functions `idx_of()` and `tag_of()`, parameterized via localparams in the user.
- Sub-module `wt_cache_array`:
  - valid/tag/data arrays;
  - one combinational read port (index) returning `valid`, `tag`, `data`;
  - one synchronous write port (index, tag, data, set-valid);
  - valid clear on `rst`.
- Top holds the FSM, request latches, and the optional counters.

## Test plan
- Cold read 0x100, memory word 0xDEADBEEF, DELAY 4 → `mem_read` 4 cycles, `cpu_rdata`=0xDEADBEEF, `miss_count`=1.
- Repeat read 0x100 → `cpu_resp` one cycle after request, no `mem_read`, `hit_count`=1.
- Write 0x100=0x12345678 then read 0x100 → `mem_write` seen with that data; read hits and returns 0x12345678.
- Write 0x200 (uncached) then read 0x200 → write does not allocate; read misses and returns memory's 0x12345678-independent stored value via `mem_read`.
- Read 0x100 then read 0x140 (same index, LINES=16) → second read misses and evicts; a third read of 0x100 misses again.
- `rst` asserted 2 cycles into a FILL → `mem_read` low the next cycle, late `mem_resp` produces no `cpu_resp`, subsequent read 0x100 misses.

Source files
------------

// File: rtl/wt_cache_pkg.sv
// Shared types and helpers for the write-through cache.
package wt_cache_pkg;

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    RESP
  } state_t;

  localparam int STAT_W = 32;

  // Word index of a byte address: bits [2 +: idx_w].
  function automatic logic [63:0] idx_of(input logic [63:0] addr, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return (addr >> 2) & mask;
  endfunction

  // Tag of a byte address: everything above the index field.
  function automatic logic [63:0] tag_of(input logic [63:0] addr, input int idx_w);
    return addr >> (2 + idx_w);
  endfunction

endpackage

// File: rtl/wt_cache_array.sv
// Direct-mapped line storage: valid bits, tags and data words.
// Combinational read port, synchronous write port, valid clear on rst.
module wt_cache_array #(
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16,
  parameter int IDX_W      = 4,
  parameter int TAG_W      = 26
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic [TAG_W-1:0]      rd_tag,
  output logic [DATA_WIDTH-1:0] rd_data,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [TAG_W-1:0]      wr_tag,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  wr_set_valid
);

  logic [LINES-1:0]      valid;
  logic [TAG_W-1:0]      tags [LINES];
  logic [DATA_WIDTH-1:0] data [LINES];

  // Valid bits: cleared on reset, set when a line is filled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    if (rst) begin
      valid <= '0;
    end else if (wr_en && wr_set_valid) begin
      valid[wr_idx] <= 1'b1;
    end
  end

  // Tag and data storage written on fills and write hits.
  always_ff @(posedge clk) begin
    // NOTE: tags/data carry no reset; the cleared valid bits make their contents irrelevant.
    if (wr_en) begin
      tags[wr_idx] <= wr_tag;
      data[wr_idx] <= wr_data;
    end
  end

  assign rd_valid = valid[rd_idx];
  assign rd_tag   = tags[rd_idx];
  assign rd_data  = data[rd_idx];

endmodule

// File: rtl/wt_cache.sv
// Direct-mapped, write-through, write-no-allocate cache.
// Optional statistics counters enabled by defining WT_CACHE_STATS_EN.
module wt_cache
  import wt_cache_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int LINES      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_read,
  input  logic                  cpu_write,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [STAT_W-1:0]     hit_count,
  output logic [STAT_W-1:0]     miss_count
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

  state_t                state, state_next;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0] lookup_addr;
  logic [IDX_W-1:0]      lookup_idx;
  logic [TAG_W-1:0]      lookup_tag;
  logic                  rd_valid;
  logic [TAG_W-1:0]      rd_tag;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  hit;
  logic                  rd_req;
  logic                  wr_en;

  // In IDLE the live request is looked up; afterwards the latched address is.
  assign lookup_addr = (state == IDLE) ? cpu_addr : addr_q;
  assign lookup_idx  = IDX_W'(idx_of(64'(lookup_addr), IDX_W));
  assign lookup_tag  = TAG_W'(tag_of(64'(lookup_addr), IDX_W));
  assign hit         = rd_valid && (rd_tag == lookup_tag);
  // A simultaneous read+write is handled as a write.
  assign rd_req      = cpu_read && !cpu_write;

  // Fills always write the line; writes only refresh a line they hit.
  assign wr_en = mem_resp && ((state == FILL) || ((state == WRITE) && hit));

  wt_cache_array #(
    .DATA_WIDTH (DATA_WIDTH),
    .LINES      (LINES),
    .IDX_W      (IDX_W),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk          (clk),
    .rst          (rst),
    .rd_idx       (lookup_idx),
    .rd_valid     (rd_valid),
    .rd_tag       (rd_tag),
    .rd_data      (rd_data),
    .wr_en        (wr_en),
    .wr_idx       (lookup_idx),
    .wr_tag       (lookup_tag),
    .wr_data      ((state == FILL) ? mem_rdata : wdata_q),
    .wr_set_valid (state == FILL)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; mem_resp outside FILL/WRITE is ignored.
  always_comb begin
    // NOTE: default first so every path assigns state_next and no latch is inferred.
    state_next = state;
    case (state)
      IDLE: begin
        if (cpu_write) begin
          state_next = WRITE;
        end else if (cpu_read) begin
          state_next = hit ? RESP : FILL;
        end
      end
      FILL:    if (mem_resp) state_next = RESP;
      WRITE:   if (mem_resp) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latches and the registered load data.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if ((state == IDLE) && (cpu_read || cpu_write)) begin
        addr_q  <= cpu_addr;
        wdata_q <= cpu_wdata;
        if (rd_req && hit) begin
          rdata_q <= rd_data;
        end
      end
      if ((state == FILL) && mem_resp) begin
        rdata_q <= mem_rdata;
      end
    end
  end

  assign cpu_resp  = (state == RESP);
  assign cpu_rdata = rdata_q;
  assign mem_read  = (state == FILL);
  assign mem_write = (state == WRITE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

`ifdef WT_CACHE_STATS_EN
  logic [STAT_W-1:0] hits_q, misses_q;

  // Saturating read hit/miss counters, updated when a read is accepted.
  always_ff @(posedge clk) begin
    if (rst) begin
      hits_q   <= '0;
      misses_q <= '0;
    end else if ((state == IDLE) && rd_req) begin
      if (hit) begin
        if (hits_q != '1) hits_q <= hits_q + STAT_W'(1);
      end else begin
        if (misses_q != '1) misses_q <= misses_q + STAT_W'(1);
      end
    end
  end

  assign hit_count  = hits_q;
  assign miss_count = misses_q;
`else
  assign hit_count  = '0;
  assign miss_count = '0;
`endif

endmodule

// File: tb/tb_wt_cache.sv
// Self-checking bench for wt_cache: transaction-level cache/memory model,
// memory responder with programmable delay, per-cycle output comparison.
module tb_wt_cache;

`ifdef WT_CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_read, cpu_write;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        cpu_resp;
  logic        mem_read, mem_write;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_resp;
  logic [31:0] hit_count, miss_count;

  wt_cache dut (
    .clk        (clk),
    .rst        (rst),
    .cpu_read   (cpu_read),
    .cpu_write  (cpu_write),
    .cpu_addr   (cpu_addr),
    .cpu_wdata  (cpu_wdata),
    .cpu_rdata  (cpu_rdata),
    .cpu_resp   (cpu_resp),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_resp   (mem_resp),
    .hit_count  (hit_count),
    .miss_count (miss_count)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %h required %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- memory behind the cache ----------------
  logic [31:0] mem_store [logic [31:0]];
  logic [31:0] ref_mem   [logic [31:0]];
  int          delay = 4;
  bit          stuck = 1'b0;
  bit          pulse = 1'b0;

  function automatic logic [31:0] default_word(input logic [31:0] a);
    return a ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] store_fetch(input logic [31:0] a);
    if (mem_store.exists(a)) return mem_store[a];
    return default_word(a);
  endfunction

  function automatic logic [31:0] ref_fetch(input logic [31:0] a);
    if (ref_mem.exists(a)) return ref_mem[a];
    return default_word(a);
  endfunction

  // Responds on the delay-th cycle a request is seen; driven just after negedge.
  initial begin
    int cnt;
    cnt = 0;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      #1;
      mem_resp = 1'b0;
      if (stuck) begin
        cnt = 0;
        if (pulse) begin
          mem_resp  = 1'b1;
          mem_rdata = 32'hBAD0_BAD0;
          pulse     = 1'b0;
        end
      end else if (mem_read || mem_write) begin
        cnt++;
        if (cnt == delay) begin
          mem_resp = 1'b1;
          cnt = 0;
          if (mem_write) mem_store[mem_addr] = mem_wdata;
          else           mem_rdata = store_fetch(mem_addr);
        end
      end else begin
        cnt = 0;
      end
    end
  end

  // ---------------- expected outputs for the next posedge ----------------
  bit          chk_en = 1'b0;
  logic        exp_resp, exp_mread, exp_mwrite;
  logic [31:0] exp_maddr, exp_mwdata, exp_rdata;
  bit          exp_rdchk, exp_all;
  int          m_hits = 0, m_misses = 0;
  int          mread_cycles = 0;
  logic [31:0] last_rdata = '0;

  task automatic set_exp(input logic resp, input logic mrd, input logic mwr,
                         input logic [31:0] maddr, input logic [31:0] mwdata,
                         input bit rdchk, input logic [31:0] rdata, input bit all);
    exp_resp   = resp;
    exp_mread  = mrd;
    exp_mwrite = mwr;
    exp_maddr  = maddr;
    exp_mwdata = mwdata;
    exp_rdchk  = rdchk;
    exp_rdata  = rdata;
    exp_all    = all;
  endtask

  // Compare process: samples 1 time unit after every rising edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (chk_en) begin
        check("cpu_resp", {31'd0, cpu_resp}, {31'd0, exp_resp});
        check("mem_read", {31'd0, mem_read}, {31'd0, exp_mread});
        check("mem_write", {31'd0, mem_write}, {31'd0, exp_mwrite});
        if (exp_mread || exp_mwrite) check("mem_addr", mem_addr, exp_maddr);
        if (exp_mwrite)              check("mem_wdata", mem_wdata, exp_mwdata);
        if (exp_resp && exp_rdchk)   check("cpu_rdata", cpu_rdata, exp_rdata);
        if (exp_all) begin
          check("rst_cpu_rdata", cpu_rdata, 32'd0);
          check("rst_mem_addr", mem_addr, 32'd0);
          check("rst_mem_wdata", mem_wdata, 32'd0);
        end
        check("hit_count", hit_count, STATS ? 32'(m_hits) : 32'd0);
        check("miss_count", miss_count, STATS ? 32'(m_misses) : 32'd0);
      end
      if (mem_read) mread_cycles++;
      if (cpu_resp) last_rdata = cpu_rdata;
    end
  end

  // ---------------- cache model (LINES=16, one word per line) ----------------
  bit          mv [16];
  logic [25:0] mt [16];
  logic [31:0] md [16];

  // One core transaction; starts and ends on a negedge.
  task automatic do_req(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    int          ix;
    logic [25:0] tg;
    bit          hit;
    logic [31:0] rv;
    ix  = int'(a[5:2]);
    tg  = a[31:6];
    hit = mv[ix] && (mt[ix] == tg);
    cpu_read  = rd;
    cpu_write = wr;
    cpu_addr  = a;
    cpu_wdata = d;
    if (wr) begin
      for (int k = 0; k < delay; k++) begin
        set_exp(1'b0, 1'b0, 1'b1, a, d, 1'b0, '0, 1'b0);
        @(negedge clk);
      end
      ref_mem[a] = d;
      if (hit) md[ix] = d;
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    end else if (hit) begin
      m_hits++;
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, md[ix], 1'b0);
    end else begin
      m_misses++;
      rv = ref_fetch(a);
      for (int k = 0; k < delay; k++) begin
        set_exp(1'b0, 1'b1, 1'b0, a, '0, 1'b0, '0, 1'b0);
        @(negedge clk);
      end
      mv[ix] = 1'b1;
      mt[ix] = tg;
      md[ix] = rv;
      set_exp(1'b1, 1'b0, 1'b0, '0, '0, 1'b1, rv, 1'b0);
    end
    @(negedge clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
  endtask

  task automatic rd_req(input logic [31:0] a);
    do_req(1'b1, 1'b0, a, 32'h0);
  endtask

  task automatic wr_req(input logic [31:0] a, input logic [31:0] d);
    do_req(1'b0, 1'b1, a, d);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    mem_store[32'h100] = 32'hDEAD_BEEF;
    ref_mem[32'h100]   = 32'hDEAD_BEEF;
    rst       = 1'b1;
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_addr  = '0;
    cpu_wdata = '0;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    chk_en = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    @(negedge clk);

    // Cold read: four mem_read cycles, loads DEADBEEF.
    delay = 4;
    mread_cycles = 0;
    rd_req(32'h100);
    check("cold_rdata", last_rdata, 32'hDEAD_BEEF);
    check("cold_mread_cycles", 32'(mread_cycles), 32'd4);
    check("cold_miss_count", miss_count, STATS ? 32'd1 : 32'd0);

    // Repeat read hits without touching memory.
    mread_cycles = 0;
    rd_req(32'h100);
    check("hit_mread_cycles", 32'(mread_cycles), 32'd0);
    check("hit_rdata", last_rdata, 32'hDEAD_BEEF);
    check("hit_hit_count", hit_count, STATS ? 32'd1 : 32'd0);

    // Write-through on a cached line, then read back from the cache.
    delay = 2;
    wr_req(32'h100, 32'h1234_5678);
    check("wt_mem_word", store_fetch(32'h100), 32'h1234_5678);
    mread_cycles = 0;
    rd_req(32'h100);
    check("wt_read_rdata", last_rdata, 32'h1234_5678);
    check("wt_read_no_mem", 32'(mread_cycles), 32'd0);

    // Write to an uncached address on the same index does not allocate.
    wr_req(32'h200, 32'hCAFE_F00D);
    mread_cycles = 0;
    rd_req(32'h100);
    check("no_alloc_keeps_line", last_rdata, 32'h1234_5678);
    check("no_alloc_hit", 32'(mread_cycles), 32'd0);
    rd_req(32'h200);
    check("uncached_read_rdata", last_rdata, 32'hCAFE_F00D);
    check("uncached_read_miss", 32'(mread_cycles), 32'd2);

    // Same-index conflict evicts.
    delay = 3;
    rd_req(32'h100);
    rd_req(32'h140);
    mread_cycles = 0;
    rd_req(32'h100);
    check("evict_remiss", 32'(mread_cycles), 32'd3);
    check("evict_rdata", last_rdata, 32'h1234_5678);

    // Read+write together acts as a write; then fill and update another index.
    delay = 1;
    do_req(1'b1, 1'b1, 32'h104, 32'h0BAD_F00D);
    rd_req(32'h104);
    check("rw_as_write_rdata", last_rdata, 32'h0BAD_F00D);
    rd_req(32'h104);
    rd_req(32'h108);
    wr_req(32'h104, 32'h0000_0077);
    mread_cycles = 0;
    rd_req(32'h104);
    check("write_hit_update", last_rdata, 32'h0000_0077);
    check("write_hit_no_mem", 32'(mread_cycles), 32'd0);

    // Reset two cycles into a FILL; a late mem_resp must be ignored.
    stuck     = 1'b1;
    cpu_read  = 1'b1;
    cpu_addr  = 32'h300;
    m_misses++;
    set_exp(1'b0, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    set_exp(1'b0, 1'b1, 1'b0, 32'h300, '0, 1'b0, '0, 1'b0);
    @(negedge clk);
    rst      = 1'b1;
    cpu_read = 1'b0;
    for (int i = 0; i < 16; i++) mv[i] = 1'b0;
    m_hits   = 0;
    m_misses = 0;
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    rst   = 1'b0;
    pulse = 1'b1;
    @(negedge clk);
    set_exp(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
    stuck = 1'b0;
    @(negedge clk);
    delay = 2;
    mread_cycles = 0;
    rd_req(32'h100);
    check("post_rst_miss", 32'(mread_cycles), 32'd2);
    check("post_rst_rdata", last_rdata, 32'h1234_5678);
    check("post_rst_miss_count", miss_count, STATS ? 32'd1 : 32'd0);

    chk_en = 1'b0;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
